tt_resp_checker: RTL
====================

# tt_resp_checker

Hardware response checker for 4-input / 2-output combinational blocks under exhaustive test. It monitors the 4-bit input vector applied to the device under test and its two outputs `f`, `g`. Once a vector has been held stable for a settle interval, it samples the outputs once, records the observed truth table and vector coverage, and compares against an expected truth table. It sits at the receiving end of the stimulus sweep and reports done/pass status when all 16 vectors have been observed.

## Interface
- `EXP_F`, 16'h0000, expected `f` truth table; bit index = `{a,b,c,d}`
- `EXP_G`, 16'h0000, expected `g` truth table; bit index = `{a,b,c,d}`
- `SETTLE`, 20, consecutive stable clock edges required before sampling; legal range 1..255
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  checking enable
- `abcd`  in  4  vector applied to DUT, `{a,b,c,d}`, a = MSB
- `f`  in  1  DUT output f
- `g`  in  1  DUT output g
- `sample_pulse`  out  1  one-cycle strobe: a sample was taken at the previous edge
- `cov`  out  16  coverage bitmap; bit v set once vector v has been sampled
- `obs_f`  out  16  observed f per vector (last sample)
- `obs_g`  out  16  observed g per vector (last sample)
- `err_cnt`  out  5  mismatching samples, saturates at 31
- `first_err_vec`  out  4  vector of the first mismatch
- `first_err_valid`  out  1  `first_err_vec` holds a valid value
- `done`  out  1  all 16 vectors covered (or early stop); sticky
- `pass`  out  1  `done && err_cnt == 0`

## Operation
- Reset: all outputs 0; internal `last_abcd` = 0; `stable_cnt` = 0; state IDLE.
- States:
  - IDLE: `en` = 0. Goes to TRACK when `en` = 1.
  - TRACK: settle counting.
  - HOLD: sampled; waiting for `abcd` to change.
  - DONE: terminal until `rst`.
- TRACK, each edge:
  - If `abcd != last_abcd`: `stable_cnt` <= 1.
  - Otherwise: `stable_cnt` increments, saturating at `SETTLE`.
  - `last_abcd` <= `abcd` on every edge in TRACK and HOLD.
- Sample: taken at the edge where `abcd == last_abcd` and `stable_cnt == SETTLE-1`, so the vector has been held for SETTLE edges. The first edge after entering TRACK counts as a change. At the sample edge:
  - `obs_f[v]` <= `f`, `obs_g[v]` <= `g`, `cov[v]` <= 1, where v = `abcd`.
  - Mismatch if `f != EXP_F[v]` or `g != EXP_G[v]`.
  - On mismatch: `err_cnt` += 1 (saturating at 31). If `first_err_valid` = 0, latch `first_err_vec` = v and set `first_err_valid`.
  - Next state: HOLD.
- HOLD: when `abcd` changes, set `stable_cnt` = 1 and return to TRACK. If a vector is revisited later, it is sampled again: `obs_*` are overwritten and errors are counted again.
- When `cov` becomes 16'hFFFF, including on the same edge as the final sample, go to DONE. `done` = 1 on the next cycle; `pass` is valid from that same cycle.
- DONE: ignores `en`, `abcd`, `f`, `g`. All outputs are frozen.
- `en` falling in TRACK/HOLD: go to IDLE and clear `stable_cnt`. `cov`, `obs_*`, `err_cnt` and first-error state are retained. Re-enabling resumes in TRACK.
- `rst` mid-sweep: returns everything to reset values on that edge; `rst` takes priority over sampling.

## Timing
- Vector applied before edge k, held stable: sample taken at edge k+SETTLE-1; `sample_pulse`, `cov`, `obs_*` and `err_cnt` update visibly after that edge.
- A change at any edge before the sample restarts the count. No partial sample is ever taken.
- `SETTLE` = 1: sample at the first edge that sees the new vector.
- `done`/`pass` latency: 1 cycle after the covering sample edge.
- `f`/`g` are sampled only at the sample edge. Glitches at other times are ignored.

## Configuration
- `TT_STOP_ON_ERR_EN` defined: the first mismatching sample moves the state to DONE on the same edge. `done` = 1 and `pass` = 0 on the next cycle, with `cov` possibly incomplete and `err_cnt` = 1.
- Not defined: the sweep always runs to full coverage and counts every mismatch.

## Test plan
- Correct DUT model: EXP_F = 16'h6996, EXP_G = 16'h8000, SETTLE = 20. Sweep 0..15 with each vector held 20 cycles and correct f/g. Required: 16 `sample_pulse`s, `cov` = 16'hFFFF, `obs_f` = 16'h6996, `obs_g` = 16'h8000, `err_cnt` = 0, `done` = `pass` = 1 one cycle after the 16th sample.
- Fault: force `g` = 1 for vector 4'h5. Required: `err_cnt` = 1, `first_err_vec` = 5, `first_err_valid` = 1, `pass` = 0. With `TT_STOP_ON_ERR_EN` defined: `done` at the vector-5 sample, `cov` = 16'h003F.
- Short hold: hold vector 3 for 19 cycles, then change it. Required: no sample and `cov[3]` = 0. A re-hold of 20 cycles samples it.
- Revisit: sample vector 2 correctly, later revisit it with wrong `f`. Required: `obs_f[2]` overwritten, `err_cnt` = 1, coverage unchanged.
- `en` = 0 mid-sweep after 8 vectors for 50 cycles, then resume. Required: `cov` = 16'h00FF retained, no samples while disabled, sweep completes with `pass` = 1.
- `rst` asserted on the edge of a sample. Required: all outputs 0 on the next cycle and no sample recorded.

Source files
------------

// File: rtl/tt_resp_checker.sv
// tt_resp_checker: truth-table response checker for a 4-input / 2-output
// combinational block under exhaustive sweep. Waits until the applied vector
// has been stable for SETTLE edges, samples f/g once, records the observed
// truth table and coverage, and compares against EXP_F/EXP_G.
//
// Parameters:
//   EXP_F, EXP_G  expected truth tables, bit index = {a,b,c,d}
//   SETTLE        stable edges required before sampling (1..255)
// Ports:
//   clk, rst                sync active-high reset
//   en                      checking enable
//   abcd, f, g              stimulus vector and DUT outputs
//   sample_pulse            sample taken at previous edge
//   cov, obs_f, obs_g       coverage bitmap and observed truth tables
//   err_cnt                 saturating mismatch count
//   first_err_vec/_valid    vector of the first mismatch
//   done, pass              sweep complete / complete without errors
// Configuration macro:
//   TT_STOP_ON_ERR_EN       first mismatch terminates the sweep immediately
module tt_resp_checker #(
  parameter logic [15:0] EXP_F  = 16'h0000,
  parameter logic [15:0] EXP_G  = 16'h0000,
  parameter int unsigned SETTLE = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  abcd,
  input  logic        f,
  input  logic        g,
  output logic        sample_pulse,
  output logic [15:0] cov,
  output logic [15:0] obs_f,
  output logic [15:0] obs_g,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err_vec,
  output logic        first_err_valid,
  output logic        done,
  output logic        pass
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [CNT_W:0]   SETTLE_W = (CNT_W+1)'(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  logic [1:0]       state, state_nxt;
  logic [3:0]       last_abcd, last_abcd_nxt;
  logic [CNT_W-1:0] stable_cnt, stable_cnt_nxt;
  logic             sample_pulse_nxt;
  logic [15:0]      cov_nxt, obs_f_nxt, obs_g_nxt;
  logic [4:0]       err_cnt_nxt;
  logic [3:0]       first_err_vec_nxt;
  logic             first_err_valid_nxt;
  logic             done_nxt, pass_nxt;

  logic             changed;
  logic [CNT_W:0]   held;
  logic             mismatch;

  // A zero count means the first edge after (re)entering TRACK: treat as a change.
  assign changed  = (abcd != last_abcd) || (stable_cnt == '0);
  // Number of consecutive edges the current vector has been seen, this edge included.
  assign held     = changed ? (CNT_W+1)'(1) : {1'b0, stable_cnt} + (CNT_W+1)'(1);
  assign mismatch = (f != EXP_F[abcd]) || (g != EXP_G[abcd]);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt           = state;
    last_abcd_nxt       = last_abcd;
    stable_cnt_nxt      = stable_cnt;
    sample_pulse_nxt    = 1'b0;
    cov_nxt             = cov;
    obs_f_nxt           = obs_f;
    obs_g_nxt           = obs_g;
    err_cnt_nxt         = err_cnt;
    first_err_vec_nxt   = first_err_vec;
    first_err_valid_nxt = first_err_valid;

    case (state)
      IDLE: begin
        if (en) state_nxt = TRACK;
      end
      TRACK, HOLD: begin
        if (!en) begin
          state_nxt      = IDLE;
          stable_cnt_nxt = '0;
        end else begin
          last_abcd_nxt = abcd;
          // HOLD only reacts to a vector change; TRACK counts every edge.
          if (state == TRACK || changed) begin
            if (held >= SETTLE_W) begin
              sample_pulse_nxt  = 1'b1;
              stable_cnt_nxt    = SETTLE_C;
              cov_nxt[abcd]     = 1'b1;
              obs_f_nxt[abcd]   = f;
              obs_g_nxt[abcd]   = g;
              if (mismatch) begin
                if (err_cnt != 5'd31) err_cnt_nxt = err_cnt + 5'd1;
                if (!first_err_valid) begin
                  first_err_vec_nxt   = abcd;
                  first_err_valid_nxt = 1'b1;
                end
              end
              state_nxt = HOLD;
              if (cov_nxt == 16'hFFFF) state_nxt = DONE;
`ifdef TT_STOP_ON_ERR_EN
              if (mismatch) state_nxt = DONE;
`endif
            end else begin
              stable_cnt_nxt = held[CNT_W-1:0];
              state_nxt      = TRACK;
            end
          end
        end
      end
      default: begin
        state_nxt = DONE;
      end
    endcase

    done_nxt = (state_nxt == DONE);
    pass_nxt = done_nxt && (err_cnt_nxt == 5'd0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_abcd       <= 4'd0;
      stable_cnt      <= '0;
      sample_pulse    <= 1'b0;
      cov             <= 16'h0000;
      obs_f           <= 16'h0000;
      obs_g           <= 16'h0000;
      err_cnt         <= 5'd0;
      first_err_vec   <= 4'd0;
      first_err_valid <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      state           <= state_nxt;
      last_abcd       <= last_abcd_nxt;
      stable_cnt      <= stable_cnt_nxt;
      sample_pulse    <= sample_pulse_nxt;
      cov             <= cov_nxt;
      obs_f           <= obs_f_nxt;
      obs_g           <= obs_g_nxt;
      err_cnt         <= err_cnt_nxt;
      first_err_vec   <= first_err_vec_nxt;
      first_err_valid <= first_err_valid_nxt;
      done            <= done_nxt;
      pass            <= pass_nxt;
    end
  end

endmodule
